// File: rtl/dot_matrix_pkg.sv
// Shared types and constants for the 16x16 dot-matrix display path.
// Pattern ROMs and the scanner both import this package.
package dot_matrix_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;

  localparam logic [ROWS-1:0] ROW_OFF   = 16'hFFFF;
  localparam logic [COLS-1:0] COL_BLANK = 16'h0000;

  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [ROWS-1:0]  row_drv_t;
  typedef logic [COLS-1:0]  col_map_t;

  function automatic row_drv_t row_drive(input row_idx_t r);
    return ~(ROWS'(1) << r);
  endfunction

endpackage

// File: rtl/row_tick_gen.sv
// Row-period phase counter: blank at count 0, tick at count CLK_DIV-1.
// The count is held at zero while scanning is disabled.
module row_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic blank,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign blank = (cnt == '0);
  assign tick  = (cnt == LAST);

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver: one blank cycle per row, column data latched once
// per row, pattern select stepped every HOLD_FRAMES frames.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int HOLD_FRAMES  = 62,
  parameter int NUM_PATTERNS = 4,
  parameter int PSEL_W       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [COLS-1:0]   col_in,
  output logic [ROW_W-1:0]  row_bin,
  output logic [PSEL_W-1:0] pattern_sel,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_out,
  output logic              frame_done
);

  localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FW-1:0]     F_LAST = FW'(HOLD_FRAMES - 1);
  localparam logic [PSEL_W-1:0] P_LAST = PSEL_W'(NUM_PATTERNS - 1);
  localparam row_idx_t          R_LAST = ROW_W'(ROWS - 1);

  logic          blank;
  logic          tick;
  logic [FW-1:0] frame_cnt;

  row_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .blank (blank),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_bin     <= '0;
      frame_cnt   <= '0;
      pattern_sel <= '0;
      row_sel     <= ROW_OFF;
      col_out     <= COL_BLANK;
      frame_done  <= 1'b0;
    end else if (!en) begin
      row_sel    <= ROW_OFF;
      col_out    <= COL_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (blank) begin
        // ROM has had the whole blank cycle to settle on row_bin
        row_sel <= row_drive(row_bin);
        col_out <= col_in;
      end else if (tick) begin
        row_sel <= ROW_OFF;
        col_out <= COL_BLANK;
        row_bin <= row_bin + ROW_W'(1);
        if (row_bin == R_LAST) begin
          frame_done <= 1'b1;
          if (frame_cnt == F_LAST) begin
            frame_cnt   <= '0;
            pattern_sel <= (pattern_sel == P_LAST) ?
                           '0 : pattern_sel + PSEL_W'(1);
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end
      end
    end
  end

endmodule
